// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE    = 2'd3;
  localparam int         MULT_CYC_DEF = 5;
  localparam int         DIV_CYC_DEF  = 10;

  typedef enum logic [2:0] {
    STG_F = 3'd0,
    STG_D = 3'd1,
    STG_E = 3'd2,
    STG_M = 3'd3,
    STG_W = 3'd4
  } stage_e;

  // A source stalls when a producer will not have its value ready by the time the source is consumed.
  function automatic logic raw_hit(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    logic e_hit, m_hit;
    e_hit = (e_wa == src) && (e_tnew > tuse);
    m_hit = (m_wa == src) && (m_tnew > tuse);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_sched.sv
// MDU occupancy tracker: loads a busy count on mult/div start and counts down.
module md_sched
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  input  logic flush,
  output logic md_busy,
  output logic md_done
);

  logic [3:0] cnt, cnt_nxt;

  // A start while busy is ignored; a start alongside a flush belongs to a squashed instr.
  always_comb begin
    cnt_nxt = cnt;
    if (cnt != 4'd0)
      cnt_nxt = cnt - 4'd1;
    else if (start && !flush)
      cnt_nxt = is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      md_busy <= (cnt_nxt != 4'd0);
      md_done <= (cnt_nxt == 4'd1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble/flush sequencer with RAW and MDU structural hazard detection.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic       D_is_md,
  input  logic [4:0] E_wa,
  input  logic [1:0] E_tnew,
  input  logic [4:0] M_wa,
  input  logic [1:0] M_tnew,
  input  logic       E_md_start,
  input  logic       E_md_is_div,
  input  logic       exc_req,
  output logic       F_en,
  output logic       D_en,
  output logic       E_clr,
  output logic       req,
  output logic       stall,
  output logic       md_busy,
  output logic       md_done
);

  logic rs_haz, rt_haz, md_haz;

  md_sched #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_md_sched (
    .clk     (clk),
    .reset   (reset),
    .start   (E_md_start),
    .is_div  (E_md_is_div),
    .flush   (exc_req),
    .md_busy (md_busy),
    .md_done (md_done)
  );

  assign rs_haz = raw_hit(D_rs, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
  assign rt_haz = raw_hit(D_rt, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);
  assign md_haz = D_is_md && (md_busy || E_md_start);

  // Every combinational control is held low while in reset; a flush overrides any stall.
  assign req   = reset && exc_req;
  assign stall = reset && (rs_haz || rt_haz || md_haz) && !exc_req;
  assign F_en  = reset && !stall;
  assign D_en  = reset && !stall;
  assign E_clr = stall;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench with a behavioural reference model and an expected-result queue.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_wa, M_wa;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic       D_is_md, E_md_start, E_md_is_div, exc_req;
  logic       F_en, D_en, E_clr, req, stall, md_busy, md_done;

  int errors = 0;
  int checks = 0;
  int mcnt   = 0;

  typedef struct {
    logic [4:0] comb;
    logic [1:0] md;
    string      tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_is_md(D_is_md), .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .exc_req(exc_req),
    .F_en(F_en), .D_en(D_en), .E_clr(E_clr), .req(req), .stall(stall),
    .md_busy(md_busy), .md_done(md_done)
  );

  function automatic bit src_haz(input logic [4:0] r, input logic [1:0] t);
    if (r == 0 || t == 2'd3) return 0;
    if (E_wa == r && int'(E_tnew) > int'(t)) return 1;
    if (M_wa == r && int'(M_tnew) > int'(t)) return 1;
    return 0;
  endfunction

  task automatic idle();
    D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3; D_is_md = 0;
    E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
    E_md_start = 0; E_md_is_div = 0; exc_req = 0;
  endtask

  // Called just after a negedge with inputs set: predict, check, then advance the model at posedge.
  task automatic tick(input string tag);
    exp_t e, got;
    bit   st;
    logic [4:0] c_obs;
    logic [1:0] m_obs;
    if (!reset) mcnt = 0;
    st = reset && (src_haz(D_rs, D_tuse_rs) || src_haz(D_rt, D_tuse_rt) ||
                   (D_is_md && (mcnt != 0 || E_md_start))) && !exc_req;
    e.comb = {reset && !st, reset && !st, st, reset && exc_req, st};
    e.md   = {mcnt != 0, mcnt == 1};
    e.tag  = tag;
    sb.push_back(e);
    #2;
    got   = sb.pop_front();
    c_obs = {F_en, D_en, E_clr, req, stall};
    m_obs = {md_busy, md_done};
    checks++;
    assert (c_obs === got.comb) else begin
      errors++;
      $error("FAIL %s ctrl{F_en,D_en,E_clr,req,stall} observed=%b expected=%b", got.tag, c_obs, got.comb);
    end
    checks++;
    assert (m_obs === got.md) else begin
      errors++;
      $error("FAIL %s md{busy,done} observed=%b expected=%b", got.tag, m_obs, got.md);
    end
    @(posedge clk);
    if (!reset) mcnt = 0;
    else if (mcnt != 0) mcnt = mcnt - 1;
    else if (E_md_start && !exc_req) mcnt = E_md_is_div ? 10 : 5;
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    E_md_start = 1; E_md_is_div = 1;
    @(negedge clk);
    tick("rst_start");
    tick("rst_hold");
    idle(); reset = 1'b1;
    tick("rst_release");

    // RAW hazards
    D_rs = 5; D_tuse_rs = 0; E_wa = 5; E_tnew = 2;
    tick("raw_e_rs");
    E_tnew = 0;
    tick("raw_e_ready");
    idle(); E_wa = 0; E_tnew = 2;
    tick("raw_zero");
    idle(); D_rt = 7; D_tuse_rt = 1; E_wa = 7; E_tnew = 1;
    tick("raw_tnew_eq_tuse");
    M_wa = 7; M_tnew = 2; E_wa = 3;
    tick("raw_m_rt");
    D_tuse_rt = 2'd3; M_tnew = 3;
    tick("raw_tuse_none");
    idle(); D_rs = 9; D_tuse_rs = 1; E_wa = 4; E_tnew = 2; M_wa = 9; M_tnew = 2;
    tick("raw_m_rs");
    exc_req = 1;
    tick("raw_with_req");

    // Divide occupancy
    idle(); E_md_start = 1; E_md_is_div = 1; D_is_md = 1;
    tick("div_t0");
    E_md_start = 0;
    for (int i = 1; i <= 11; i++) begin
      if (i == 4) begin E_md_start = 1; E_md_is_div = 0; end
      else E_md_start = 0;
      if (i == 11) D_is_md = 0;
      tick($sformatf("div_t%0d", i));
    end
    tick("div_idle");

    // Start squashed by exception
    idle(); E_md_start = 1; E_md_is_div = 0; exc_req = 1; D_is_md = 1;
    tick("start_exc");
    idle();
    tick("start_exc_next");
    tick("start_exc_next2");

    // Exception mid-mult does not abort it
    E_md_start = 1;
    tick("mul_t0");
    E_md_start = 0;
    tick("mul_t1");
    tick("mul_t2");
    exc_req = 1;
    tick("mul_t3_exc");
    exc_req = 0;
    for (int i = 4; i <= 7; i++) tick($sformatf("mul_t%0d", i));

    // Async reset mid-mult kills it without a done pulse
    E_md_start = 1;
    tick("mul2_t0");
    E_md_start = 0;
    tick("mul2_t1");
    tick("mul2_t2");
    tick("mul2_t3");
    #1 reset = 1'b0;
    #1;
    checks++;
    assert (md_busy === 1'b0 && md_done === 1'b0) else begin
      errors++;
      $error("FAIL async_rst md{busy,done} observed=%b%b expected=00", md_busy, md_done);
    end
    @(negedge clk);
    tick("mul2_rst");
    reset = 1'b1;
    for (int i = 0; i < 6; i++) tick($sformatf("post_rst%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
